button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Upstream conditioning stage for the single-pulse generator; its debounced level drives that FSM's button input directly.
- Synchronises the raw, bouncing, asynchronous push-button signal into the clock domain.
- Accepts a level change only after it has held for STABLE_CYCLES consecutive samples.
- Exposes a bounce-activity flag and a saturating count of rejected glitches for bring-up and debug.

Parameters:
SYNC_STAGES, 2, synchroniser flip-flop depth; legal range >= 2.
STABLE_CYCLES, 1000000, consecutive identical synchronised samples required to accept a new level (10 ms at 100 MHz); legal range >= 1.
RESET_LEVEL, 1'b0, inactive button level; reset value of the synchroniser chain and of button_o.
CNT_WIDTH, $clog2(STABLE_CYCLES+1), stability counter width; derived, do not override.

Ports:
clk_i  input  1  system clock, rising edge.
rst_n_i  input  1  reset, asynchronous assert, active-low.
button_raw_i  input  1  raw pad signal; asynchronous and bouncing.
button_o  output  1  debounced, synchronised button level.
bouncing_o  output  1  high while a candidate level change is being qualified.
glitch_cnt_o  output  8  number of aborted qualifications; saturates at 255.

Behaviour:
- Reset is asynchronous and active-low. While rst_n_i = 0, all of the following hold without a clock edge:
  - synchroniser stages = RESET_LEVEL
  - button_o = RESET_LEVEL
  - state = STABLE, counter = 0
  - bouncing_o = 0, glitch_cnt_o = 0
- Synchroniser: a SYNC_STAGES-deep flop chain on button_raw_i. The last stage is sync_s. No logic sits between stages.
- The FSM has two states, and bouncing_o = (state == CHECK).
- STABLE state:
  - If sync_s == button_o: stay in STABLE.
  - If sync_s != button_o and STABLE_CYCLES == 1: toggle button_o at this edge and stay in STABLE.
  - If sync_s != button_o and STABLE_CYCLES > 1: go to CHECK and set cnt to 1.
- CHECK state:
  - If sync_s == button_o (bounce back): go to STABLE, set cnt to 0, and increment glitch_cnt_o unless it is 255. button_o is unchanged.
  - Else if cnt == STABLE_CYCLES-1: toggle button_o, go to STABLE, set cnt to 0.
  - Else: increment cnt and stay in CHECK.
- Latency:
  - Count the first edge that samples the new raw level as edge 1.
  - button_o changes at edge SYNC_STAGES + STABLE_CYCLES, provided the raw level holds throughout.
  - A raw pulse shorter than STABLE_CYCLES samples never changes button_o.
- button_o is a registered output with no combinational path from button_raw_i, and it toggles at most once per qualification.
- Press and release are qualified identically; there is no polarity-specific logic. RESET_LEVEL only sets the post-reset value.
- glitch_cnt_o holds at 255 once reached and clears only on reset.
- Reset asserted mid-CHECK: the qualification is abandoned immediately. After release, the block restarts from STABLE with button_o = RESET_LEVEL.
- The counter never exceeds STABLE_CYCLES-1, and no wrap-around is possible.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES = 2, STABLE_CYCLES = 4, RESET_LEVEL = 0, 10 ns clock.
1. Async reset: drive rst_n_i = 0 between clock edges with button_raw_i = 1 -> button_o = 0, bouncing_o = 0, glitch_cnt_o = 0 immediately, before any edge.
2. Clean press: button_raw_i 0->1 and held ->
   - button_o rises exactly at edge 6 (edge 1 = first sampling edge).
   - bouncing_o is high for exactly 3 cycles before the rise.
   - glitch_cnt_o stays 0.
3. Bouncy press: raw sequence 1,1,0,1,0,0,1 then held 1 (one value per cycle) ->
   - button_o rises once, 6 edges after the final 0->1.
   - glitch_cnt_o = 2.
   - No intermediate toggle of button_o.
4. Clean release: from button_o = 1, raw goes to 0 and is held -> button_o falls at edge 6; a following 2-cycle raw 1 blip leaves button_o = 0 and increments glitch_cnt_o by 1.
5. Saturation: 300 raw pulses, each 2 cycles high and 8 cycles low -> button_o stays 0 and glitch_cnt_o = 255 at the end.
6. Reset mid-CHECK: raw high for 3 cycles, assert rst_n_i for 1 cycle, release with raw = 0 -> button_o = 0 throughout, bouncing_o = 0 after reset, glitch_cnt_o = 0.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises a bouncing pad signal and accepts a new
// level only after STABLE_CYCLES identical samples; counts aborted qualifications.
module button_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter logic        RESET_LEVEL   = 1'b0,
  parameter int unsigned CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       button_raw_i,
  output logic       button_o,
  output logic       bouncing_o,
  output logic [7:0] glitch_cnt_o
);

  typedef enum logic {
    ST_STABLE,
    ST_CHECK
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   button_q, button_d;
  logic [7:0]             glitch_q, glitch_d;

  // Plain flop chain: nothing may sit between synchroniser stages.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_raw_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      button_q <= RESET_LEVEL;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      button_q <= button_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    button_d = button_q;
    glitch_d = glitch_q;
    case (state_q)
      ST_STABLE: begin
        if (sync_s != button_q) begin
          // A single required sample means the change is accepted on sight.
          if (STABLE_CYCLES == 1) begin
            button_d = ~button_q;
          end else begin
            state_d = ST_CHECK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_CHECK: begin
        if (sync_s == button_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          if (glitch_q != '1) begin
            glitch_d = glitch_q + 8'd1;
          end
        end else if (cnt_q == CNT_LAST) begin
          button_d = ~button_q;
          state_d  = ST_STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign button_o     = button_q;
  assign bouncing_o   = (state_q == ST_CHECK);
  assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_button_debouncer;

  typedef struct {
    logic       raw;
    logic       b;
    logic       bn;
    logic [7:0] g;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       raw   = 1'b0;
  logic       b;
  logic       bn;
  logic [7:0] g;

  int total = 0;
  int bad   = 0;

  vec_t exp_q[$];
  vec_t press_tbl[7];
  vec_t release_tbl[13];
  vec_t bouncy_tbl[13];

  always #5 clk = ~clk;

  button_debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .button_raw_i(raw),
    .button_o    (b),
    .bouncing_o  (bn),
    .glitch_cnt_o(g)
  );

  function automatic vec_t mk(logic r, logic eb, logic ebn, int unsigned eg);
    vec_t v;
    v.raw = r;
    v.b   = eb;
    v.bn  = ebn;
    v.g   = 8'(eg);
    return v;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(string nm, logic eb, logic ebn, logic [7:0] eg);
    check($sformatf("%s button_o", nm), {7'd0, b}, {7'd0, eb});
    check($sformatf("%s bouncing_o", nm), {7'd0, bn}, {7'd0, ebn});
    check($sformatf("%s glitch_cnt_o", nm), g, eg);
  endtask

  // Drive one raw sample, queue its expectation, compare after the sampling edge.
  task automatic step(string nm, vec_t v);
    vec_t e;
    raw = v.raw;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("%s scoreboard empty", nm), 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check_outs(nm, e.b, e.bn, e.g);
    end
  endtask

  task automatic do_reset(logic raw_during);
    #2;
    raw   = raw_during;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    raw   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after reset", 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    press_tbl = '{mk(1,0,0,0), mk(1,0,0,0), mk(1,0,1,0), mk(1,0,1,0),
                  mk(1,0,1,0), mk(1,1,0,0), mk(1,1,0,0)};
    release_tbl = '{mk(0,1,0,0), mk(0,1,0,0), mk(0,1,1,0), mk(0,1,1,0),
                    mk(0,1,1,0), mk(0,0,0,0), mk(0,0,0,0),
                    mk(1,0,0,0), mk(1,0,0,0), mk(0,0,1,0), mk(0,0,1,0),
                    mk(0,0,0,1), mk(0,0,0,1)};
    bouncy_tbl = '{mk(1,0,0,0), mk(1,0,0,0), mk(0,0,1,0), mk(1,0,1,0),
                   mk(0,0,0,1), mk(0,0,1,1), mk(1,0,0,2), mk(1,0,0,2),
                   mk(1,0,1,2), mk(1,0,1,2), mk(1,0,1,2), mk(1,1,0,2),
                   mk(1,1,0,2)};

    // 1: async reset with raw high, outputs checked before any edge
    raw = 1'b1;
    @(posedge clk);
    @(posedge clk);
    do_reset(1'b1);

    // 2: clean press, rise at edge 6
    for (int i = 0; i < 7; i++) step($sformatf("press[%0d]", i), press_tbl[i]);

    // 4: clean release then 2-cycle blip
    for (int i = 0; i < 13; i++) step($sformatf("release[%0d]", i), release_tbl[i]);

    // 3: bouncy press from a fresh reset
    do_reset(1'b0);
    for (int i = 0; i < 13; i++) step($sformatf("bouncy[%0d]", i), bouncy_tbl[i]);

    // 5: glitch counter saturation
    do_reset(1'b0);
    for (int p = 1; p <= 300; p++) begin
      for (int s = 1; s <= 10; s++) begin
        int unsigned eg;
        eg = unsigned'(p - 1) + ((s >= 5) ? 1 : 0);
        if (eg > 255) eg = 255;
        step($sformatf("sat[%0d.%0d]", p, s),
             mk((s <= 2) ? 1'b1 : 1'b0, 1'b0, (s == 3 || s == 4) ? 1'b1 : 1'b0, eg));
      end
    end
    check("sat final glitch_cnt_o", g, 8'd255);

    // 6: reset in the middle of a qualification
    do_reset(1'b0);
    step("midchk[0]", mk(1, 0, 0, 0));
    step("midchk[1]", mk(1, 0, 0, 0));
    step("midchk[2]", mk(1, 0, 1, 0));
    #2;
    rst_n = 1'b0;
    raw   = 1'b0;
    #1;
    check_outs("midchk in reset", 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step($sformatf("midchk post[%0d]", i), mk(0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
